ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//  Read-side engine for the single-port weight RAM (16-bit data/addr, registered
//  read address, q valid one clock after addr). On a start pulse it walks a
//  contiguous address window and emits each word on a valid/ready stream to the
//  CNN MAC datapath. A 2-entry skid buffer absorbs the RAM's 1-cycle read latency
//  under backpressure. It drives ram_we low at all times.
// PARAMETERS
//  FRT_CELL  10   default window base address (used when cfg_base_sel=0)
//  BCK_CELL  5    default window length = FRT_CELL*BCK_CELL words (cfg_base_sel=0)
//  ADDR_W    16   RAM address width
//  DATA_W    16   RAM data width (two's complement)
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       synchronous, active-high reset
//  start         in   1       1-cycle pulse; accepted only in IDLE
//  cfg_base_sel  in   1       0: use FRT_CELL/FRT_CELL*BCK_CELL; 1: use cfg_base/cfg_len
//  cfg_base      in   ADDR_W  window base address, sampled with start
//  cfg_len       in   ADDR_W  window length in words, sampled with start
//  busy          out  1       high from accepted start until done pulse
//  done          out  1       1-cycle pulse after last word handshaken
//  ram_addr      out  ADDR_W  address to RAM addr port
//  ram_we        out  1       RAM write enable, constant 0
//  ram_data      out  DATA_W  RAM write data, constant 0
//  ram_q         in   DATA_W  RAM read data (valid 1 clk after ram_addr)
//  m_valid       out  1       stream word valid
//  m_ready       in   1       downstream ready
//  m_data        out  DATA_W  stream word
//  m_last        out  1       high with final word of window
//  chk_err       out  1       sticky ramp-mismatch flag (see CONFIGURATION)
//  chk_cnt       out  8       saturating mismatch count
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, m_valid=0, m_last=0, m_data=0,
//    ram_addr=0, chk_err=0, chk_cnt=0; skid buffer emptied; counters cleared.
//  - FSM: IDLE -start-> RUN (len!=0) or DONE (len==0); RUN -last addr issued-> DRAIN;
//    DRAIN -buffer empty and no read in flight-> DONE; DONE -1 cycle-> IDLE.
//  - Read issue in RUN: present ram_addr=base+k when (inflight + buffered) < 2;
//    the word arrives on ram_q the next cycle and is written into the skid buffer.
//  - Stream: m_data/m_valid come from head of skid buffer; pop on m_valid&m_ready.
//    Words are emitted strictly in address order; no loss or duplication under
//    any m_ready pattern. Sustained throughput is 1 word/clk when m_ready=1.
//  - Latency: first m_valid two cycles after the start cycle.
//  - m_last asserted with word index len-1 only; done pulses the cycle after
//    that word's handshake; busy drops together with done.
//  - Address arithmetic is modulo 2^ADDR_W: base+k wraps 0xFFFF -> 0x0000.
//  - start while busy: ignored. start in DONE cycle: ignored.
//  - m_valid, once high, holds with m_data stable until the handshake.
//  - reset mid-operation: abort immediately to reset state; no done pulse; any
//    in-flight RAM read is discarded.
// CONFIGURATION
//  - CHECK_RAMP_EN defined: each emitted word k is compared to -250 + 10*k
//    (DATA_W two's complement); on mismatch at handshake, chk_err sets (sticky
//    until reset or next accepted start) and chk_cnt increments, saturating 255.
//  - CHECK_RAMP_EN undefined: comparator absent; chk_err and chk_cnt tied to 0.
// TESTING
//  - Default window, m_ready=1, RAM preloaded: start,cfg_base_sel=0 -> 50 words
//    on addr 10..59, data -250,-240,...,240; m_last on 240; done 1 clk later.
//  - cfg_base=0x0020, cfg_len=4, m_ready toggling 1010... -> exactly 4 words,
//    in order, each m_data held stable while m_valid&!m_ready.
//  - cfg_base=0xFFFE, cfg_len=3 -> reads 0xFFFE,0xFFFF,0x0000; m_last on 3rd word.
//  - cfg_len=0 -> no m_valid, done pulses 1 clk after start, busy never held >1 clk.
//  - reset asserted after 5th word of 50 -> all outputs at reset values next clk,
//    no done; new start then replays from word 0.
//  - CHECK_RAMP_EN: write 0x0000 at addr 12 then default run -> chk_err=1,
//    chk_cnt=1; without macro chk_err=0, chk_cnt=0.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: RAM read port and output stream bundle for the
// weight-RAM stream reader. The master side is the reader; the slave side is
// the RAM plus the downstream consumer.
interface ram_stream_reader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output ram_addr, ram_we, ram_data, m_valid, m_data, m_last,
        input  ram_q, m_ready
    );

    modport slave (
        input  ram_addr, ram_we, ram_data, m_valid, m_data, m_last,
        output ram_q, m_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a contiguous window of the single-port weight RAM
// and emits each word, in address order, on a valid/ready stream. A 2-entry
// skid buffer absorbs the one-cycle RAM read latency under backpressure; a
// word arriving on ram_q is forwarded straight to the stream when the buffer
// is empty, which gives first m_valid two cycles after start and 1 word/clk.
// Optional build macro: CHECK_RAMP_EN adds a ramp comparator on the emitted
// words (chk_err/chk_cnt); without it both outputs are tied to zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; window config sampled on an accepted start
// RUN   | issuing reads while (in-flight + buffered) < 2
// DRAIN | all addresses issued; emptying the skid buffer
// DONE  | one-cycle done pulse, then back to IDLE
module ram_stream_reader #(
    parameter int FRT_CELL = 10,
    parameter int BCK_CELL = 5,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                cfg_base_sel,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W-1:0]   cfg_len,
    output logic                busy,
    output logic                done,
    ram_stream_reader_if.master bus,
    output logic                chk_err,
    output logic [7:0]          chk_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] DEF_BASE = ADDR_W'(FRT_CELL);
    localparam logic [ADDR_W-1:0] DEF_LEN  = ADDR_W'(FRT_CELL * BCK_CELL);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    state_t            state, state_nx;

    logic [ADDR_W-1:0] addr_r;      // next address to present to the RAM
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] iss_cnt;     // reads issued so far
    logic [ADDR_W-1:0] out_cnt;     // words handshaken so far
    logic              rd_pend;     // ram_q holds the word read last cycle

    logic [DATA_W-1:0] skid [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        cnt;

    logic [ADDR_W-1:0] sel_base, sel_len;
    logic              accept, issue, last_issue;
    logic              valid, pop, pop_buf, push, last_word;
    logic [DATA_W-1:0] head;

    // Window selection, read-issue gating and skid-buffer head / bypass
    always_comb begin
        sel_base   = cfg_base_sel ? cfg_base : DEF_BASE;
        sel_len    = cfg_base_sel ? cfg_len  : DEF_LEN;
        accept     = (state == IDLE) && start;
        issue      = (state == RUN) && (({1'b0, rd_pend} + cnt) < 2'd2);
        last_issue = issue && (iss_cnt == (len_r - ONE_A));
        valid      = (cnt != 2'd0) || rd_pend;
        head       = (cnt != 2'd0) ? skid[rd_ptr] : bus.ram_q;
        pop        = valid && bus.m_ready;
        pop_buf    = pop && (cnt != 2'd0);
        // A fresh word bypasses the buffer only if it is consumed right away
        push       = rd_pend && !((cnt == 2'd0) && pop);
        last_word  = (out_cnt == (len_r - ONE_A));
    end

    // Stream and RAM outputs; write side of the RAM is never used
    always_comb begin
        bus.m_valid  = valid;
        bus.m_data   = valid ? head : '0;
        bus.m_last   = valid && last_word;
        bus.ram_addr = addr_r;
        bus.ram_we   = 1'b0;
        bus.ram_data = '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (sel_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // The last word always reaches the stream after RUN has ended
                if (pop && last_word) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Address/length registers, counters and skid-buffer bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r  <= '0;
            len_r   <= '0;
            iss_cnt <= '0;
            out_cnt <= '0;
            rd_pend <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (accept) begin
                addr_r  <= sel_base;
                len_r   <= sel_len;
                iss_cnt <= '0;
                out_cnt <= '0;
            end else begin
                if (issue) begin
                    addr_r  <= addr_r + ONE_A;
                    iss_cnt <= iss_cnt + ONE_A;
                end
                if (pop) begin
                    out_cnt <= out_cnt + ONE_A;
                end
            end
            rd_pend <= issue;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_buf) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop_buf) begin
                cnt <= cnt + 2'd1;
            end else if (!push && pop_buf) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

    // Skid-buffer storage; contents are only meaningful while cnt says so
    always_ff @(posedge clk) begin
        if (push) begin
            skid[wr_ptr] <= bus.ram_q;
        end
    end

`ifdef CHECK_RAMP_EN
    localparam logic [DATA_W-1:0] RAMP_BASE = DATA_W'(-250);
    localparam logic [DATA_W-1:0] RAMP_STEP = DATA_W'(10);

    logic [DATA_W-1:0] ramp_exp;

    // Compare every handshaken word with the expected ramp; sticky flag and
    // saturating count are cleared by reset or by the next accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_err  <= 1'b0;
            chk_cnt  <= 8'd0;
            ramp_exp <= RAMP_BASE;
        end else if (accept) begin
            chk_err  <= 1'b0;
            chk_cnt  <= 8'd0;
            ramp_exp <= RAMP_BASE;
        end else if (pop) begin
            ramp_exp <= ramp_exp + RAMP_STEP;
            if (head != ramp_exp) begin
                chk_err <= 1'b1;
                if (chk_cnt != 8'hFF) begin
                    chk_cnt <= chk_cnt + 8'd1;
                end
            end
        end
    end
`else
    assign chk_err = 1'b0;
    assign chk_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: bench for ram_stream_reader with a behavioural RAM and
// a reference model that derives expected streams directly from the window
// definition (base, length, address wrap) and the bench's own memory image.
module tb_ram_stream_reader;

`ifdef CHECK_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cfg_base_sel;
    logic [15:0] cfg_base;
    logic [15:0] cfg_len;
    logic        busy;
    logic        done;
    logic        chk_err;
    logic [7:0]  chk_cnt;

    int checks   = 0;
    int failures = 0;

    ram_stream_reader_if bus ();

    ram_stream_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_base_sel (cfg_base_sel),
        .cfg_base     (cfg_base),
        .cfg_len      (cfg_len),
        .busy         (busy),
        .done         (done),
        .bus          (bus),
        .chk_err      (chk_err),
        .chk_cnt      (chk_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [65536];

    // Behavioural RAM: registered read, q valid one clock after the address
    always @(posedge clk) begin
        bus.ram_q <= mem[bus.ram_addr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ramp(int k);
        return 16'(-250 + 10 * k);
    endfunction

    function automatic logic ready_for(int mode, int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            2:       return ($urandom % 2) == 0;
            default: return ($urandom % 4) == 0;
        endcase
    endfunction

    // Observations of the most recent run
    logic [15:0] obs_words[$];
    int          obs_lasts[$];
    int          obs_first, obs_done, obs_last_hs, obs_hold, obs_busy;
    logic        obs_busy_after, obs_done_after;
    bit          obs_timeout;

    // Starts one window and records what the stream did; cycle 0 is the start
    // cycle. With noise set, start stays high (with random config) through the
    // DONE cycle so ignored starts are exercised.
    task automatic run_stream(input logic sel, input logic [15:0] base,
                              input logic [15:0] len, input int mode, input bit noise);
        logic        pv, pr, pl;
        logic [15:0] pd;
        bit          fin;
        int          lim;
        obs_words.delete();
        obs_lasts.delete();
        obs_first = -1; obs_done = -1; obs_last_hs = -1; obs_hold = 0; obs_busy = 0;
        obs_busy_after = 1'bx; obs_done_after = 1'bx; obs_timeout = 1'b1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0;
        lim = (sel ? int'(len) : 50) * 8 + 40;
        @(posedge clk); #1;
        start = 1'b1; cfg_base_sel = sel; cfg_base = base; cfg_len = len;
        bus.m_ready = ready_for(mode, 0);
        for (int c = 0; c < lim && !fin; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = noise && (obs_done < 0);
                if (noise) begin
                    cfg_base_sel = 1'($urandom); cfg_base = 16'($urandom); cfg_len = 16'($urandom);
                end
                bus.m_ready = ready_for(mode, c);
            end
            @(negedge clk);
            if (pv && !pr) begin
                if (bus.m_valid !== 1'b1 || bus.m_data !== pd || bus.m_last !== pl) obs_hold++;
            end
            if (bus.m_valid === 1'b1) begin
                if (obs_first < 0) obs_first = c;
                if (bus.m_ready === 1'b1) begin
                    obs_words.push_back(bus.m_data);
                    if (bus.m_last === 1'b1) obs_lasts.push_back(obs_words.size() - 1);
                    obs_last_hs = c;
                end
            end
            if (obs_done >= 0) begin
                obs_busy_after = busy;
                obs_done_after = done;
                obs_timeout = 1'b0;
                fin = 1'b1;
            end else begin
                if (busy === 1'b1) obs_busy++;
                if (done === 1'b1) obs_done = c;
            end
            pv = bus.m_valid; pr = bus.m_ready; pd = bus.m_data; pl = bus.m_last;
        end
        start = 1'b0; cfg_base_sel = 1'b0; cfg_base = '0; cfg_len = '0;
        bus.m_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cfg_base_sel = 1'b0; cfg_base = '0; cfg_len = '0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last: got %b expected 0", bus.m_last); end
        checks++; if (bus.m_data !== 16'h0) begin failures++; $display("FAIL reset_m_data: got %h expected 0000", bus.m_data); end
        checks++; if (bus.ram_addr !== 16'h0) begin failures++; $display("FAIL reset_ram_addr: got %h expected 0000", bus.ram_addr); end
        checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we: got %b expected 0", bus.ram_we); end
        checks++; if (bus.ram_data !== 16'h0) begin failures++; $display("FAIL reset_ram_data: got %h expected 0000", bus.ram_data); end
        checks++; if (chk_err !== 1'b0 || chk_cnt !== 8'd0) begin failures++; $display("FAIL reset_chk: got err=%b cnt=%0d expected 0/0", chk_err, chk_cnt); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_default_window();
        run_stream(1'b0, 16'h0, 16'h0, 0, 1'b0);
        checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL default_timeout: got 1 expected 0"); end
        checks++; if (obs_words.size() != 50) begin failures++; $display("FAIL default_count: got %0d expected 50", obs_words.size()); end
        for (int k = 0; k < 50; k++) begin
            logic [15:0] got;
            got = (k < obs_words.size()) ? obs_words[k] : 16'hxxxx;
            checks++; if (got !== ramp(k)) begin failures++; $display("FAIL default_word[%0d]: got %h expected %h", k, got, ramp(k)); end
        end
        checks++; if (obs_lasts.size() != 1 || obs_lasts[0] != 49) begin failures++; $display("FAIL default_last: got %0d last flags expected one on index 49", obs_lasts.size()); end
        checks++; if (obs_first != 2) begin failures++; $display("FAIL default_latency: got %0d expected 2", obs_first); end
        checks++; if (obs_last_hs != obs_first + 49) begin failures++; $display("FAIL default_throughput: got %0d expected %0d", obs_last_hs, obs_first + 49); end
        checks++; if (obs_done != obs_last_hs + 1) begin failures++; $display("FAIL default_done: got %0d expected %0d", obs_done, obs_last_hs + 1); end
        checks++; if (obs_busy != obs_done) begin failures++; $display("FAIL default_busy_len: got %0d expected %0d", obs_busy, obs_done); end
        checks++; if (obs_busy_after !== 1'b0 || obs_done_after !== 1'b0) begin failures++; $display("FAIL default_after: got busy=%b done=%b expected 0/0", obs_busy_after, obs_done_after); end
        checks++; if (chk_err !== 1'b0 || chk_cnt !== 8'd0) begin failures++; $display("FAIL default_chk: got err=%b cnt=%0d expected 0/0", chk_err, chk_cnt); end
    endtask

    // Shared comparison body would be a check helper, so each window test
    // below spells its comparisons out against the memory image.
    task automatic test_backpressure();
        run_stream(1'b1, 16'h0020, 16'd4, 1, 1'b0);
        checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL bp_timeout: got 1 expected 0"); end
        checks++; if (obs_words.size() != 4) begin failures++; $display("FAIL bp_count: got %0d expected 4", obs_words.size()); end
        for (int k = 0; k < 4; k++) begin
            logic [15:0] got;
            got = (k < obs_words.size()) ? obs_words[k] : 16'hxxxx;
            checks++; if (got !== mem[16'(16'h0020 + k)]) begin failures++; $display("FAIL bp_word[%0d]: got %h expected %h", k, got, mem[16'(16'h0020 + k)]); end
        end
        checks++; if (obs_hold != 0) begin failures++; $display("FAIL bp_hold: got %0d violations expected 0", obs_hold); end
        checks++; if (obs_lasts.size() != 1 || obs_lasts[0] != 3) begin failures++; $display("FAIL bp_last: got %0d last flags expected one on index 3", obs_lasts.size()); end
        checks++; if (obs_done != obs_last_hs + 1) begin failures++; $display("FAIL bp_done: got %0d expected %0d", obs_done, obs_last_hs + 1); end
    endtask

    task automatic test_wrap();
        run_stream(1'b1, 16'hFFFE, 16'd3, 2, 1'b0);
        checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL wrap_timeout: got 1 expected 0"); end
        checks++; if (obs_words.size() != 3) begin failures++; $display("FAIL wrap_count: got %0d expected 3", obs_words.size()); end
        for (int k = 0; k < 3; k++) begin
            logic [15:0] got, a;
            a   = 16'(32'hFFFE + k);
            got = (k < obs_words.size()) ? obs_words[k] : 16'hxxxx;
            checks++; if (got !== mem[a]) begin failures++; $display("FAIL wrap_word[%0d]: got %h expected %h", k, got, mem[a]); end
        end
        checks++; if (obs_lasts.size() != 1 || obs_lasts[0] != 2) begin failures++; $display("FAIL wrap_last: got %0d last flags expected one on index 2", obs_lasts.size()); end
        checks++; if (obs_hold != 0) begin failures++; $display("FAIL wrap_hold: got %0d violations expected 0", obs_hold); end
    endtask

    task automatic test_zero_len();
        run_stream(1'b1, 16'h1234, 16'd0, 0, 1'b0);
        checks++; if (obs_first != -1) begin failures++; $display("FAIL zero_valid: got m_valid at cycle %0d expected none", obs_first); end
        checks++; if (obs_done != 1) begin failures++; $display("FAIL zero_done: got %0d expected 1", obs_done); end
        checks++; if (obs_busy != 1) begin failures++; $display("FAIL zero_busy: got %0d cycles expected 1", obs_busy); end
        checks++; if (obs_busy_after !== 1'b0) begin failures++; $display("FAIL zero_after: got busy=%b expected 0", obs_busy_after); end
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        int bad = 0;
        @(posedge clk); #1;
        start = 1'b1; cfg_base_sel = 1'b0; bus.m_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) begin @(posedge clk); #1; start = 1'b0; end
            @(negedge clk);
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                if (bus.m_data !== ramp(hs)) bad++;
                hs++;
            end
            if (hs == 5) break;
        end
        start = 1'b0;
        checks++; if (hs != 5 || bad != 0) begin failures++; $display("FAIL mid_prefix: got %0d words (%0d wrong) expected 5 (0 wrong)", hs, bad); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({busy, done, bus.m_valid, bus.m_last} !== 4'b0) begin failures++; $display("FAIL mid_flags: got busy/done/valid/last=%b expected 0000", {busy, done, bus.m_valid, bus.m_last}); end
        checks++; if (bus.m_data !== 16'h0 || bus.ram_addr !== 16'h0) begin failures++; $display("FAIL mid_data_addr: got data=%h addr=%h expected 0000/0000", bus.m_data, bus.ram_addr); end
        checks++; if (chk_err !== 1'b0 || chk_cnt !== 8'd0) begin failures++; $display("FAIL mid_chk: got err=%b cnt=%0d expected 0/0", chk_err, chk_cnt); end
        @(posedge clk); #1 reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || bus.m_valid !== 1'b0 || busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mid_quiet: got %0d active cycles expected 0", bad); end
        run_stream(1'b0, 16'h0, 16'h0, 2, 1'b0);
        checks++; if (obs_words.size() != 50) begin failures++; $display("FAIL mid_replay_count: got %0d expected 50", obs_words.size()); end
        bad = 0;
        for (int k = 0; k < obs_words.size(); k++) if (obs_words[k] !== ramp(k)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL mid_replay_words: got %0d wrong expected 0", bad); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] base, len;
            int          mode, bad;
            bit          noise;
            base  = (i == 0) ? 16'hFFF8 : 16'($urandom);
            len   = 16'($urandom_range(1, 20));
            mode  = $urandom_range(0, 3);
            noise = (i % 2) == 1;
            run_stream(1'b1, base, len, mode, noise);
            checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL rnd%0d_timeout: got 1 expected 0", i); end
            checks++; if (obs_words.size() != int'(len)) begin failures++; $display("FAIL rnd%0d_count: got %0d expected %0d", i, obs_words.size(), len); end
            bad = 0;
            for (int k = 0; k < obs_words.size() && k < int'(len); k++)
                if (obs_words[k] !== mem[16'(base + k)]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL rnd%0d_words: got %0d wrong expected 0", i, bad); end
            checks++; if (obs_lasts.size() != 1 || obs_lasts[0] != int'(len) - 1) begin failures++; $display("FAIL rnd%0d_last: got %0d last flags expected one on index %0d", i, obs_lasts.size(), len - 1); end
            checks++; if (obs_hold != 0) begin failures++; $display("FAIL rnd%0d_hold: got %0d violations expected 0", i, obs_hold); end
            checks++; if (obs_done != obs_last_hs + 1) begin failures++; $display("FAIL rnd%0d_done: got %0d expected %0d", i, obs_done, obs_last_hs + 1); end
            checks++; if (obs_busy_after !== 1'b0) begin failures++; $display("FAIL rnd%0d_after: got busy=%b expected 0", i, obs_busy_after); end
        end
    endtask

    task automatic test_ramp_check();
        mem[12] = 16'h0000;
        run_stream(1'b0, 16'h0, 16'h0, 0, 1'b0);
        checks++; if (chk_err !== RAMP_EN) begin failures++; $display("FAIL ramp_err: got %b expected %b", chk_err, RAMP_EN); end
        checks++; if (chk_cnt !== (RAMP_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL ramp_cnt: got %0d expected %0d", chk_cnt, RAMP_EN ? 1 : 0); end
        mem[12] = ramp(2);
        run_stream(1'b0, 16'h0, 16'h0, 3, 1'b0);
        checks++; if (chk_err !== 1'b0 || chk_cnt !== 8'd0) begin failures++; $display("FAIL ramp_clear: got err=%b cnt=%0d expected 0/0", chk_err, chk_cnt); end
    endtask

    task automatic test_ramp_saturate();
        int mm = 0;
        logic [7:0] exp_cnt;
        for (int k = 0; k < 300; k++) if (mem[16'(16'h3000 + k)] !== ramp(k)) mm++;
        exp_cnt = RAMP_EN ? 8'((mm > 255) ? 255 : mm) : 8'd0;
        run_stream(1'b1, 16'h3000, 16'd300, 0, 1'b0);
        checks++; if (obs_words.size() != 300) begin failures++; $display("FAIL sat_count: got %0d expected 300", obs_words.size()); end
        checks++; if (chk_cnt !== exp_cnt) begin failures++; $display("FAIL sat_cnt: got %0d expected %0d", chk_cnt, exp_cnt); end
        checks++; if (chk_err !== (RAMP_EN && mm > 0)) begin failures++; $display("FAIL sat_err: got %b expected %b", chk_err, RAMP_EN && mm > 0); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        for (int k = 0; k < 50; k++) mem[10 + k] = ramp(k);
        test_reset();
        test_default_window();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_reset_mid();
        test_random();
        test_ramp_check();
        test_ramp_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
